fetch_unit: RTL and testbench

Parametrised instruction fetch front-end that succeeds the single-cycle PC/adder/instruction-memory path. It owns the fetch PC and issues requests to an instruction memory of arbitrary latency over a valid/ready handshake. Returned instructions are buffered, together with their PC, in a DEPTH-entry FIFO that feeds decode through a valid/ready handshake. A one-cycle redirect flushes the FIFO, squashes in-flight responses and restarts fetch at a branch target.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues in-order requests to a
// variable-latency instruction memory and buffers {pc, instr} pairs for decode.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);
    localparam logic [PW-1:0]         PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [CW:0]           OCC_LIMIT = (CW + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0]  r_fetch_pc;
    logic [ADDR_WIDTH-1:0]  r_rsp_pc;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          r_inflight;
    logic [CW-1:0]          r_drop_cnt;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_wr_ptr;
    logic [ADDR_WIDTH-1:0]  r_buf_pc    [DEPTH];
    logic [INSTR_WIDTH-1:0] r_buf_instr [DEPTH];

    logic [CW:0]           w_occ;
    logic                  w_req_valid;
    logic                  w_req_fire;
    logic                  w_rsp_take;
    logic                  w_rsp_drop;
    logic                  w_push;
    logic                  w_out_valid;
    logic                  w_pop;
    logic [CW-1:0]         w_inflight_nxt;
    logic [ADDR_WIDTH-1:0] w_redir_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Buffered plus in-flight fetches never exceed DEPTH, so a push always has room.
    assign w_occ       = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_req_valid = !reset && !redirect_valid && (w_occ < OCC_LIMIT);
    assign w_req_fire  = w_req_valid && imem_req_ready;

    // A response with nothing outstanding is spurious and ignored entirely.
    assign w_rsp_take  = imem_rsp_valid && (r_inflight != '0);
    assign w_rsp_drop  = w_rsp_take && (r_drop_cnt != '0);
    assign w_push      = w_rsp_take && !w_rsp_drop && !redirect_valid;

    assign w_out_valid = !reset && (r_count != '0);
    assign w_pop       = w_out_valid && out_ready && !redirect_valid;

    assign w_inflight_nxt = r_inflight + CW'(w_req_fire) - CW'(w_rsp_take);
    assign w_redir_pc     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign out_valid      = w_out_valid;
    assign out_pc         = w_out_valid ? r_buf_pc[r_rd_ptr]    : '0;
    assign out_instr      = w_out_valid ? r_buf_instr[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (redirect_valid) begin
                // Everything still outstanding after this cycle belongs to the old path.
                r_fetch_pc <= w_redir_pc;
                r_rsp_pc   <= w_redir_pc;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_drop_cnt <= w_inflight_nxt;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_STEP;
                if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + PC_STEP;
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_buf_pc[r_wr_ptr]    <= r_rsp_pc;
            r_buf_instr[r_wr_ptr] <= imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based model of request tags and buffered entries,
// a latency-programmable memory, and directed scenarios with literal expectations.
module tb_fetch_unit;
    localparam int AW = 64;
    localparam int IW = 32;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] RESET_PC = '0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b1;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;

    fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; int due; }           mreq_t;
    typedef struct { logic [AW-1:0] addr; bit stale; }         ost_t;
    typedef struct { logic [AW-1:0] pc; logic [IW-1:0] instr; } ent_t;

    mreq_t         mem_q[$];
    ost_t          m_out[$];
    ent_t          m_fifo[$];
    ent_t          pop_log[$];
    logic [AW-1:0] m_pc = RESET_PC;
    int lat = 1, gcyc = 0, since = 0, acc_cnt = 0, first_ov = -1;
    bit spur = 1'b0;
    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [AW-1:0] pc);
        logic [31:0] lo;
        lo = pc[31:0];
        if (pop_log.size() <= idx) begin
            checks++;
            failures++;
            $display("FAIL %s: got %0d pops expected more than %0d", name, pop_log.size(), idx);
        end else begin
            chk(name, pop_log[idx].pc, pc);
            chk({name, "_instr"}, {32'h0, pop_log[idx].instr}, {32'h0, lo ^ 32'hA5A5_0000});
        end
    endtask

    // Memory: answers accepted requests in order, lat cycles later.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk); #2;
            gcyc++;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (mem_q.size() > 0 && mem_q[0].due <= gcyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_q[0].addr[31:0] ^ 32'hA5A5_0000;
                void'(mem_q.pop_front());
            end else if (spur) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    // Model: every accepted request is a tag; a redirect marks all tags stale.
    initial begin
        forever begin : cmp
            logic e_req_v, e_out_v;
            ost_t o;
            @(negedge clk);
            e_req_v = !reset && !redirect_valid && (m_fifo.size() + m_out.size() < DEPTH);
            e_out_v = !reset && (m_fifo.size() > 0);
            chk("req_valid", {63'h0, imem_req_valid}, {63'h0, e_req_v});
            if (e_req_v) chk("req_addr", imem_req_addr, m_pc);
            chk("out_valid", {63'h0, out_valid}, {63'h0, e_out_v});
            if (e_out_v) begin
                chk("out_pc", out_pc, m_fifo[0].pc);
                chk("out_instr", {32'h0, out_instr}, {32'h0, m_fifo[0].instr});
            end else if (m_fifo.size() == 0) begin
                chk("out_pc_idle", out_pc, '0);
                chk("out_instr_idle", {32'h0, out_instr}, '0);
            end
            if (reset) begin
                mem_q.delete();
                m_out.delete();
                m_fifo.delete();
                m_pc = RESET_PC;
                since = 0;
                first_ov = -1;
            end else begin
                if (out_valid && first_ov < 0) first_ov = since;
                since++;
                if (imem_req_valid && imem_req_ready) begin
                    mem_q.push_back('{imem_req_addr, gcyc + lat});
                    acc_cnt++;
                end
                if (redirect_valid) begin
                    if (imem_rsp_valid && m_out.size() > 0) void'(m_out.pop_front());
                    foreach (m_out[i]) m_out[i].stale = 1'b1;
                    m_fifo.delete();
                    m_pc = {redirect_pc[AW-1:2], 2'b00};
                end else begin
                    if (e_out_v && out_ready) begin
                        pop_log.push_back(m_fifo[0]);
                        void'(m_fifo.pop_front());
                    end
                    if (imem_rsp_valid && m_out.size() > 0) begin
                        o = m_out.pop_front();
                        if (!o.stale) m_fifo.push_back('{o.addr, imem_rsp_data});
                    end
                    if (e_req_v && imem_req_ready) begin
                        m_out.push_back('{m_pc, 1'b0});
                        m_pc = m_pc + 64'd4;
                    end
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Leaves the bench at the start of post-reset cycle 0.
    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        spur = 1'b0;
        step(2);
        reset = 1'b0;
        pop_log.delete();
    endtask

    initial begin
        // 1: 1-cycle memory, streaming
        lat = 1; out_ready = 1'b1; imem_req_ready = 1'b1;
        do_reset();
        step(12);
        chk("t1_first_valid_cycle", 64'(first_ov), 64'd2);
        chk("t1_pop_count", 64'(pop_log.size()), 64'd10);
        chk_log("t1_pc0", 0, 64'h0);
        chk_log("t1_pc1", 1, 64'h4);
        chk_log("t1_pc2", 2, 64'h8);
        chk_log("t1_pc7", 7, 64'h1C);
        if (pop_log.size() > 0) chk("t1_instr0_lit", {32'h0, pop_log[0].instr}, 64'hA5A5_0000);

        // 2: decode stalled, occupancy cap, spurious response while idle
        out_ready = 1'b0;
        do_reset();
        acc_cnt = 0;
        step(9);
        spur = 1'b1;
        step(1);
        spur = 1'b0;
        @(negedge clk);
        chk("t2_req_valid_full", {63'h0, imem_req_valid}, 64'h0);
        chk("t2_accepted", 64'(acc_cnt), 64'd4);
        chk("t2_model_count", 64'(m_fifo.size()), 64'd4);
        step(1);
        out_ready = 1'b1;
        step(8);
        chk_log("t2_pc0", 0, 64'h0);
        chk_log("t2_pc1", 1, 64'h4);
        chk_log("t2_pc2", 2, 64'h8);
        chk_log("t2_pc3", 3, 64'hC);
        chk_log("t2_pc4", 4, 64'h10);

        // 3: latency 3, redirect with two in flight, unaligned target
        lat = 3;
        do_reset();
        step(2);
        redirect_valid = 1'b1; redirect_pc = 64'h1003;
        step(1);
        redirect_valid = 1'b0;
        step(8);
        chk_log("t3_pc0", 0, 64'h1000);
        chk_log("t3_pc1", 1, 64'h1004);
        if (pop_log.size() > 0) chk("t3_instr0_lit", {32'h0, pop_log[0].instr}, 64'hA5A5_1000);

        // 4: redirect coincident with response and pop, count = 2
        lat = 1; out_ready = 1'b0;
        do_reset();
        step(3);
        redirect_valid = 1'b1; redirect_pc = 64'h2000; out_ready = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_out_valid_cleared", {63'h0, out_valid}, 64'h0);
        chk("t4_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("t4_req_addr", imem_req_addr, 64'h2000);
        step(6);
        chk_log("t4_pc0", 0, 64'h2000);
        chk_log("t4_pc1", 1, 64'h2004);

        // 5: address wrap
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        step(1);
        redirect_valid = 1'b0;
        step(8);
        chk_log("t5_pc0", 0, 64'hFFFF_FFFF_FFFF_FFF8);
        chk_log("t5_pc1", 1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk_log("t5_pc2", 2, 64'h0);
        chk_log("t5_pc3", 3, 64'h4);
        if (pop_log.size() > 0) chk("t5_instr0_lit", {32'h0, pop_log[0].instr}, 64'h5A5A_FFF8);

        // 6: reset mid-stream with count = 3, inflight = 1
        out_ready = 1'b0;
        do_reset();
        step(4);
        chk("t6_model_count", 64'(m_fifo.size()), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_out_valid_in_reset", {63'h0, out_valid}, 64'h0);
        chk("t6_req_valid_in_reset", {63'h0, imem_req_valid}, 64'h0);
        step(1);
        reset = 1'b0;
        pop_log.delete();
        @(negedge clk);
        chk("t6_out_valid", {63'h0, out_valid}, 64'h0);
        chk("t6_out_pc", out_pc, 64'h0);
        chk("t6_out_instr", {32'h0, out_instr}, 64'h0);
        chk("t6_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("t6_req_addr", imem_req_addr, RESET_PC);
        step(1);
        out_ready = 1'b1;
        step(6);
        chk_log("t6_pc0", 0, 64'h0);

        // 7: back-to-back redirects, latency 3
        lat = 3;
        do_reset();
        step(2);
        redirect_valid = 1'b1; redirect_pc = 64'h3000;
        step(1);
        redirect_pc = 64'h4008;
        step(1);
        redirect_valid = 1'b0;
        step(10);
        chk_log("t7_pc0", 0, 64'h4008);
        chk_log("t7_pc1", 1, 64'h400C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
